uart_tx_msg_arbiter: RTL and testbench
======================================

Name: uart_tx_msg_arbiter

Overview:
- Shares the single UART TX FIFO write port (8-bit data plus write-enable) between up to NUM_REQ message sources, for example the distance reporter, the temp/humidity reporter and the error reporter.
- Arbitration is round-robin at message granularity. Once a source is granted, it owns the port until it writes its last byte, drops its request, or times out.
- Sits between the per-sensor ASCII message FSMs and the TX FIFO.

Parameters:
- NUM_REQ, 3, number of requesting sources (2..8).
- TIMEOUT_CYC, 1_000_000, idle cycles allowed within a granted message before forced release (10 ms at 100 MHz).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  per-source request; held high for the whole message.
- wr_en  input  NUM_REQ  per-source byte strobe; honoured only when that source's ready bit is high.
- wr_data  input  8*NUM_REQ  per-source ASCII byte; source i occupies bits [8i+7:8i].
- wr_last  input  NUM_REQ  marks the final byte of a message (CR/LF terminator); qualified by wr_en.
- fifo_full  input  1  TX FIFO full flag.
- grant  output  NUM_REQ  one-hot registered grant.
- ready  output  NUM_REQ  grant[i] AND NOT fifo_full (combinational).
- fifo_wdata  output  8  registered byte to the FIFO.
- fifo_we  output  1  registered one-cycle write pulse.
- busy  output  1  high in GRANT and RELEASE.
- timeout  output  1  one-cycle pulse on forced release.
- drop_err  output  1  sticky; set when wr_en arrives while the matching ready bit is low; cleared only by reset.

Behaviour:
- Reset (reset=0, asynchronous):
  - State=IDLE; grant, fifo_we, fifo_wdata, timeout and drop_err all 0.
  - Round-robin pointer last=NUM_REQ-1, so source 0 has first priority.
  - Timeout counter=0.
  - Reset asserted mid-message aborts the message: no partial-byte flush, and the FIFO keeps whatever it already holds.
- IDLE:
  - If any req bit is high, pick the first set bit searching last+1, last+2, … with wrap modulo NUM_REQ.
  - At the next edge: grant[sel]=1, state=GRANT, counter cleared.
  - Grant latency is 1 cycle from the edge that samples req.
- GRANT:
  - A byte is accepted when wr_en[g] & ready[g].
  - At that edge fifo_wdata<=wr_data[g] and fifo_we<=1; otherwise fifo_we<=0. This gives 1-cycle latency to the FIFO.
  - Each accepted byte clears the counter; cycles with no accepted byte increment it, including cycles stalled on fifo_full.
  - Exit conditions, checked in this priority order:
    1. Accepted byte with wr_last[g] → RELEASE. The last byte is still written.
    2. req[g]==0 → RELEASE. Any byte accepted in that same cycle is still written.
    3. counter==TIMEOUT_CYC-1 → RELEASE, and timeout pulses for 1 cycle at that edge.
  - On the edge entering RELEASE: grant<=0 and last<=g.
- RELEASE:
  - Lasts exactly 1 cycle with no grant, guaranteeing a gap between messages.
  - Then → IDLE. Arbitration resumes there with the updated pointer.
- wr_en from non-granted sources, or from the granted source while fifo_full=1:
  - The byte is ignored, not forwarded, and drop_err<=1.
  - This also applies in IDLE and RELEASE.
- Only the granted source's wr_data/wr_last are examined. Multiple simultaneous req bits are resolved purely by the pointer.
- fifo_we never asserts while fifo_full was high in the accepting cycle.
- fifo_wdata holds its last value when fifo_we=0.

Decomposition:
- Shared package: state encodings IDLE=0, GRANT=1, RELEASE=2; ASCII constants CR=8'h0D and LF=8'h0A, reused by the message FSMs.
- One sub-module: rr_pick (combinational). Inputs are req and last; outputs are the one-hot sel and a valid flag. It is reusable by other shared-resource arbiters.

Test Plan:
- Single source: req=001; send "12cm\r\n" with wr_last on 0x0A → grant=001 one cycle after req; fifo_we sequence 0x31,0x32,0x63,0x6D,0x0D,0x0A, each one cycle after its wr_en; one RELEASE cycle with grant=000, then IDLE.
- Round-robin: req=111 held; each source sends a 2-byte message → grant order 001, 010, 100, 001, with exactly one grant=000 cycle between messages.
- Backpressure: fifo_full=1 for 5 cycles mid-message → ready=0 and no fifo_we during the stall; source waits; remaining bytes are delivered in order once full deasserts; drop_err stays 0.
- Timeout: TIMEOUT_CYC=16; the granted source stops strobing → timeout pulses on the 16th idle cycle; grant drops; the next requester is granted after RELEASE.
- Protocol errors:
  - wr_en from non-granted source 2 during source 0's message → byte not written; drop_err=1 and stays 1.
  - req[0] dropped mid-message → RELEASE on the next edge.
- Reset mid-message: reset pulsed low asynchronously between clock edges → grant=0 and fifo_we=0 immediately; after release, req=110 grants source 1 first.

Source files
------------

// File: rtl/uart_tx_msg_arbiter_pkg.sv
// Shared definitions for the UART TX message arbiter and the ASCII message FSMs
// that feed it.
package uart_tx_msg_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Index width for an N-entry one-hot vector, never narrower than 1 bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_msg_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after index last_i,
// wrapping modulo NUM_REQ.
module uart_tx_msg_arbiter_rr_pick
  import uart_tx_msg_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IW      = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      last_i,
  output logic [NUM_REQ-1:0] sel_o,
  output logic               valid_o
);

  logic [IW-1:0] cand;

  always_comb begin
    sel_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((32'(last_i) + k) % NUM_REQ);
      if (!valid_o && req_i[cand]) begin
        sel_o[cand] = 1'b1;
        valid_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_msg_arbiter.sv
// Message-granular round-robin arbiter sharing one UART TX FIFO write port
// between NUM_REQ ASCII message sources.
module uart_tx_msg_arbiter
  import uart_tx_msg_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 3,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     wr_en,
  input  logic [8*NUM_REQ-1:0]   wr_data,
  input  logic [NUM_REQ-1:0]     wr_last,
  input  logic                   fifo_full,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     ready,
  output logic [7:0]             fifo_wdata,
  output logic                   fifo_we,
  output logic                   busy,
  output logic                   timeout,
  output logic                   drop_err
);

  localparam int unsigned IW = idx_width(NUM_REQ);
  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  arb_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [IW-1:0]       gidx_q, gidx_d;
  logic [IW-1:0]       last_q, last_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [7:0]          wdata_q, wdata_d;
  logic                to_q, to_d;
  logic                drop_q, drop_d;

  logic [NUM_REQ-1:0]  sel;
  logic                sel_valid;
  logic [IW-1:0]       sel_idx;
  logic [7:0]          data_arr [NUM_REQ];
  logic                acc;

  uart_tx_msg_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr_pick (
    .req_i   (req),
    .last_i  (last_q),
    .sel_o   (sel),
    .valid_o (sel_valid)
  );

  always_comb begin
    sel_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (sel[i]) sel_idx = IW'(i);
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      data_arr[i] = wr_data[8*i +: 8];
    end
  end

  // grant_q is zero outside GRANT, so ready and acc are inherently state-gated.
  assign ready = grant_q & ~{NUM_REQ{fifo_full}};
  assign acc   = wr_en[gidx_q] & ready[gidx_q];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    wdata_d = wdata_q;
    to_d    = 1'b0;
    drop_d  = drop_q | (|(wr_en & ~ready));

    case (state_q)
      IDLE: begin
        if (sel_valid) begin
          state_d = GRANT;
          grant_d = sel;
          gidx_d  = sel_idx;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (acc) begin
          we_d    = 1'b1;
          wdata_d = data_arr[gidx_q];
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        if ((acc && wr_last[gidx_q]) || !req[gidx_q] ||
            (cnt_q == CW'(TIMEOUT_CYC - 1))) begin
          state_d = RELEASE;
          grant_d = '0;
          last_d  = gidx_q;
          to_d    = !(acc && wr_last[gidx_q]) && req[gidx_q];
        end
      end
      RELEASE: state_d = IDLE;
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      cnt_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      to_q    <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      to_q    <= to_d;
      drop_q  <= drop_d;
    end
  end

  assign grant      = grant_q;
  assign fifo_we    = we_q;
  assign fifo_wdata = wdata_q;
  assign timeout    = to_q;
  assign drop_err   = drop_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_msg_arbiter.sv
// Directed bench for uart_tx_msg_arbiter with a byte scoreboard on the FIFO port.
module tb_uart_tx_msg_arbiter;
  import uart_tx_msg_arbiter_pkg::*;

  localparam int unsigned N = 3;

  logic         clk;
  logic         reset;
  logic [N-1:0] req;
  logic [N-1:0] wr_en;
  logic [8*N-1:0] wr_data;
  logic [N-1:0] wr_last;
  logic         fifo_full;
  logic [N-1:0] grant;
  logic [N-1:0] ready;
  logic [7:0]   fifo_wdata;
  logic         fifo_we;
  logic         busy;
  logic         timeout;
  logic         drop_err;

  logic [7:0]   d_arr [N];
  logic [7:0]   exp_q [$];
  int           checks;
  int           failures;

  assign wr_data = {d_arr[2], d_arr[1], d_arr[0]};

  uart_tx_msg_arbiter #(
    .NUM_REQ     (N),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_last    (wr_last),
    .fifo_full  (fifo_full),
    .grant      (grant),
    .ready      (ready),
    .fifo_wdata (fifo_wdata),
    .fifo_we    (fifo_we),
    .busy       (busy),
    .timeout    (timeout),
    .drop_err   (drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one byte from src for one edge; push to the scoreboard when it should reach the FIFO.
  task automatic send_byte(input int src, input logic [7:0] d, input bit last, input bit push);
    wr_en[src]   = 1'b1;
    d_arr[src]   = d;
    wr_last[src] = last;
    if (push) exp_q.push_back(d);
    tick();
    wr_en[src]   = 1'b0;
    wr_last[src] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset && fifo_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_fifo_we", 32'(fifo_wdata), 32'hFFFF_FFFF);
      end else begin
        chk("fifo_byte", 32'(fifo_wdata), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    logic [7:0] msg [6];
    checks    = 0;
    failures  = 0;
    reset     = 1'b0;
    req       = '0;
    wr_en     = '0;
    wr_last   = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < int'(N); i++) d_arr[i] = '0;

    // Reset state
    #12;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_we", 32'(fifo_we), 32'd0);
    chk("rst_wdata", 32'(fifo_wdata), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_drop", 32'(drop_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick();
    reset = 1'b1;

    // Single source: "12cm\r\n"
    msg[0] = 8'h31; msg[1] = 8'h32; msg[2] = 8'h63;
    msg[3] = 8'h6D; msg[4] = ASCII_CR; msg[5] = ASCII_LF;
    req = 3'b001;
    tick();
    chk("single_grant", 32'(grant), 32'b001);
    chk("single_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 6; i++) send_byte(0, msg[i], (i == 5), 1'b1);
    req = '0;
    chk("single_release_grant", 32'(grant), 32'd0);
    chk("single_release_busy", 32'(busy), 32'd1);
    tick();
    chk("single_idle_busy", 32'(busy), 32'd0);
    chk("single_idle_grant", 32'(grant), 32'd0);

    // Round-robin with all sources requesting; pointer now at 0
    req = 3'b111;
    tick();
    chk("rr_grant_1", 32'(grant), 32'b010);
    send_byte(1, 8'h41, 1'b0, 1'b1);
    send_byte(1, 8'h42, 1'b1, 1'b1);
    chk("rr_gap_1", 32'(grant), 32'd0);
    tick();
    chk("rr_idle_1", 32'(grant), 32'd0);
    tick();
    chk("rr_grant_2", 32'(grant), 32'b100);
    send_byte(2, 8'h43, 1'b0, 1'b1);
    send_byte(2, 8'h44, 1'b1, 1'b1);
    chk("rr_gap_2", 32'(grant), 32'd0);
    tick();
    tick();
    chk("rr_grant_0", 32'(grant), 32'b001);
    send_byte(0, 8'h45, 1'b0, 1'b1);
    send_byte(0, 8'h46, 1'b1, 1'b1);
    chk("rr_gap_0", 32'(grant), 32'd0);
    tick();
    tick();
    chk("rr_grant_1b", 32'(grant), 32'b010);

    // req dropped mid-message: release on the next edge, byte still written
    send_byte(1, 8'h47, 1'b0, 1'b1);
    req = '0;
    tick();
    chk("reqdrop_grant", 32'(grant), 32'd0);
    chk("reqdrop_busy", 32'(busy), 32'd1);
    chk("reqdrop_timeout", 32'(timeout), 32'd0);
    tick();

    // Backpressure: pointer at 1, only source 0 requests
    req = 3'b001;
    tick();
    chk("bp_grant", 32'(grant), 32'b001);
    send_byte(0, 8'h61, 1'b0, 1'b1);
    fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_ready", 32'(ready), 32'd0);
      chk("bp_no_we", 32'(fifo_we), 32'd0);
    end
    fifo_full = 1'b0;
    #1;
    chk("bp_ready_back", 32'(ready), 32'b001);
    send_byte(0, 8'h62, 1'b0, 1'b1);
    send_byte(0, ASCII_LF, 1'b1, 1'b1);
    req = '0;
    chk("bp_drop_clear", 32'(drop_err), 32'd0);
    tick();

    // Timeout: pointer at 0, req=101 picks source 2 which never strobes
    req = 3'b101;
    tick();
    chk("to_grant", 32'(grant), 32'b100);
    for (int i = 0; i < 15; i++) begin
      tick();
      chk("to_early", 32'({timeout, grant}), 32'b0100);
    end
    tick();
    chk("to_pulse", 32'(timeout), 32'd1);
    chk("to_grant_drop", 32'(grant), 32'd0);
    tick();
    chk("to_pulse_end", 32'(timeout), 32'd0);
    tick();
    chk("to_next_grant", 32'(grant), 32'b001);

    // Protocol error: source 2 strobes during source 0's message
    wr_en[2] = 1'b1;
    d_arr[2] = 8'h5A;
    send_byte(0, 8'h78, 1'b0, 1'b1);
    wr_en[2] = 1'b0;
    chk("drop_set", 32'(drop_err), 32'd1);
    send_byte(0, ASCII_LF, 1'b1, 1'b1);
    req = '0;
    chk("drop_sticky", 32'(drop_err), 32'd1);
    tick();
    tick();
    chk("drop_sticky_idle", 32'(drop_err), 32'd1);

    // Reset mid-message, asserted between edges
    req = 3'b001;
    tick();
    chk("mr_grant", 32'(grant), 32'b001);
    send_byte(0, 8'h39, 1'b0, 1'b0);
    #1;
    reset = 1'b0;
    #1;
    chk("mr_grant_clr", 32'(grant), 32'd0);
    chk("mr_we_clr", 32'(fifo_we), 32'd0);
    chk("mr_drop_clr", 32'(drop_err), 32'd0);
    req = 3'b110;
    tick();
    reset = 1'b1;
    tick();
    chk("mr_first_grant", 32'(grant), 32'b010);
    req = '0;
    tick();
    tick();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
